ex_muldiv_unit: RTL and testbench
=================================

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have port CLK  in  1  rising-edge clock, the pipeline clock.
REQ-002 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port EX_Opcode  in  6  opcode from the ID/EX pipeline register.
REQ-004 SHALL have port EX_Funct  in  6  funct field from the ID/EX pipeline register.
REQ-005 SHALL have port EX_RS_Data  in  32  rs operand: dividend / multiplicand / MTHI-MTLO source.
REQ-006 SHALL have port EX_RT_Data  in  32  rt operand: divisor / multiplier.
REQ-007 SHALL have port MD_STALL  out  1  combinational hold request to the PC, IF/ID and ID/EX registers.
REQ-008 SHALL have port MD_BUSY  out  1  registered; high while in BUSY state.
REQ-009 SHALL have port MD_RESULT  out  32  combinational HI (MFHI) or LO (MFLO) read data, else 0.
REQ-010 SHALL have port MD_RESULT_SEL  out  1  high when the EX instruction is MFHI or MFLO, so the EX mux takes MD_RESULT.
REQ-011 SHALL have port HI  out  32  registered HI register.
REQ-012 SHALL have port LO  out  32  registered LO register.

Function
REQ-013 SHALL decode only when EX_Opcode=6'h00, with funct MULT=18, MULTU=19, DIV=1A, DIVU=1B, MFHI=10, MTHI=11, MFLO=12, MTLO=13 (hex); all other codes are no-ops.
REQ-014 SHALL implement a three-state machine: IDLE, BUSY, DONE.
REQ-015 SHALL move IDLE->BUSY on a clock edge when a MULT/MULTU/DIV/DIVU is decoded, latching the operands and clearing a 6-bit iteration counter.
REQ-016 SHALL retire one bit per cycle in BUSY, shift-add for multiply and restoring for divide, and move BUSY->DONE after exactly 32 iterations.
REQ-017 SHALL write HI/LO on the BUSY->DONE edge, and always move DONE->IDLE on the next edge.
REQ-018 SHALL ignore a decoded mul/div op while in DONE (the same instruction is still held in EX), so it never restarts.
REQ-019 SHALL drive MD_STALL = (IDLE and mul/div decoded) or BUSY, and low in DONE.
REQ-020 SHALL produce a timeline where a mul/div occupies EX for 34 cycles and MD_STALL is high for exactly 33 consecutive cycles.
REQ-021 SHALL compute MULTU/DIVU unsigned, giving {HI,LO} as a 64-bit product, LO the quotient and HI the remainder.
REQ-022 SHALL compute MULT/DIV on magnitudes, then negate the product/quotient when the operand signs differ and give the remainder the dividend's sign.
REQ-023 SHALL produce LO=32'hFFFFFFFF and HI=dividend (unmodified) for a divide by zero, signed or unsigned, still taking 34 cycles.
REQ-024 SHALL write HI/LO for MTHI/MTLO on the clock edge while IDLE, with no stall.
REQ-025 SHALL drive MD_RESULT combinationally from the current HI/LO for MFHI/MFLO in IDLE, with no stall.
REQ-026 SHALL treat DIV 0x80000000 / 0xFFFFFFFF as LO=0x80000000, HI=0 (wrap, no trap).

Reset
REQ-027 SHALL force state=IDLE, counter=0, HI=0, LO=0, MD_BUSY=0 and internal operand/accumulator registers=0 while RESET is high, independent of CLK.
REQ-028 SHALL abandon an in-flight operation on RESET mid-BUSY, with no HI/LO update and MD_STALL low immediately.
REQ-029 SHALL accept a new operation on the first clock edge after RESET deasserts.

Verification
REQ-030 SHALL pass: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> MD_STALL high 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 SHALL pass: MULT 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-032 SHALL pass: DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-033 SHALL pass: DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5, stall length 33.
REQ-034 SHALL pass: MTHI 0x1234, then MFHI next cycle -> MD_RESULT=0x1234, MD_RESULT_SEL=1, MD_STALL=0 throughout.
REQ-035 SHALL pass: RESET at iteration 10 of MULTU 2x3 -> MD_STALL=0, HI=LO=0; MULTU 2x3 reissued -> LO=6, HI=0.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: 32-cycle shift-add multiply and
// restoring divide on operand magnitudes, with HI/LO registers and a pipeline hold request.
module ex_muldiv_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [5:0]  EX_Opcode,
    input  logic [5:0]  EX_Funct,
    input  logic [31:0] EX_RS_Data,
    input  logic [31:0] EX_RT_Data,
    output logic        MD_STALL,
    output logic        MD_BUSY,
    output logic [31:0] MD_RESULT,
    output logic        MD_RESULT_SEL,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    // state | meaning
    // IDLE  | waiting; MTHI/MTLO/MFHI/MFLO serviced here, mul/div start on decode
    // BUSY  | one quotient/product bit retired per cycle, 32 cycles
    // DONE  | result in HI/LO; the finished instruction is still in EX and is ignored
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    state_t      state;
    logic [5:0]  iter_cnt;
    logic [63:0] acc;
    logic [31:0] opb;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        div_zero;

    logic        is_rtype, dec_mult, dec_multu, dec_div, dec_divu;
    logic        dec_mfhi, dec_mthi, dec_mflo, dec_mtlo;
    logic        dec_start, dec_signed, dec_isdiv;
    logic        rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag;

    assign is_rtype   = (EX_Opcode == 6'h00);
    assign dec_mult   = is_rtype && (EX_Funct == F_MULT);
    assign dec_multu  = is_rtype && (EX_Funct == F_MULTU);
    assign dec_div    = is_rtype && (EX_Funct == F_DIV);
    assign dec_divu   = is_rtype && (EX_Funct == F_DIVU);
    assign dec_mfhi   = is_rtype && (EX_Funct == F_MFHI);
    assign dec_mthi   = is_rtype && (EX_Funct == F_MTHI);
    assign dec_mflo   = is_rtype && (EX_Funct == F_MFLO);
    assign dec_mtlo   = is_rtype && (EX_Funct == F_MTLO);
    assign dec_start  = dec_mult | dec_multu | dec_div | dec_divu;
    assign dec_signed = dec_mult | dec_div;
    assign dec_isdiv  = dec_div | dec_divu;

    assign rs_neg = dec_signed & EX_RS_Data[31];
    assign rt_neg = dec_signed & EX_RT_Data[31];
    assign rs_mag = rs_neg ? -EX_RS_Data : EX_RS_Data;
    assign rt_mag = rt_neg ? -EX_RT_Data : EX_RT_Data;

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [63:0] div_next;
    logic [63:0] acc_next;

    assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    assign mul_next  = {mul_sum, acc[31:1]};
    assign div_shift = {acc[63:32], acc[31]};
    assign div_ge    = (div_shift >= {1'b0, opb});
    assign div_diff  = div_shift - {1'b0, opb};
    assign div_next  = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc[30:0], div_ge};
    assign acc_next  = is_div ? div_next : mul_next;

    // A zero divisor leaves the dividend magnitude in the remainder, so the sign fix restores it exactly
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, hi_fin, lo_fin;

    assign prod_fix = neg_res ? -acc_next : acc_next;
    assign quo_fix  = div_zero ? 32'hFFFF_FFFF : (neg_res ? -acc_next[31:0] : acc_next[31:0]);
    assign rem_fix  = neg_rem ? -acc_next[63:32] : acc_next[63:32];
    assign hi_fin   = is_div ? rem_fix : prod_fix[63:32];
    assign lo_fin   = is_div ? quo_fix : prod_fix[31:0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            iter_cnt <= 6'd0;
            acc      <= 64'd0;
            opb      <= 32'd0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            MD_BUSY  <= 1'b0;
            HI       <= 32'd0;
            LO       <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (dec_start) begin
                        state    <= BUSY;
                        MD_BUSY  <= 1'b1;
                        iter_cnt <= 6'd0;
                        is_div   <= dec_isdiv;
                        neg_res  <= rs_neg ^ rt_neg;
                        neg_rem  <= dec_isdiv & rs_neg;
                        div_zero <= dec_isdiv & (EX_RT_Data == 32'd0);
                        opb      <= dec_isdiv ? rt_mag : rs_mag;
                        acc      <= {32'd0, (dec_isdiv ? rs_mag : rt_mag)};
                    end else begin
                        if (dec_mthi) HI <= EX_RS_Data;
                        if (dec_mtlo) LO <= EX_RS_Data;
                    end
                end
                BUSY: begin
                    acc      <= acc_next;
                    iter_cnt <= iter_cnt + 6'd1;
                    if (iter_cnt == 6'd31) begin
                        state   <= DONE;
                        MD_BUSY <= 1'b0;
                        HI      <= hi_fin;
                        LO      <= lo_fin;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign MD_STALL      = ~RESET & (((state == IDLE) & dec_start) | (state == BUSY));
    assign MD_RESULT_SEL = dec_mfhi | dec_mflo;
    assign MD_RESULT     = dec_mfhi ? HI : (dec_mflo ? LO : 32'd0);
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed and random mul/div ops against an
// arithmetic reference, HI/LO moves, mid-operation reset and back-to-back issue.
module tb_ex_muldiv_unit;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        CLK;
    logic        RESET;
    logic [5:0]  EX_Opcode;
    logic [5:0]  EX_Funct;
    logic [31:0] EX_RS_Data;
    logic [31:0] EX_RT_Data;
    logic        MD_STALL;
    logic        MD_BUSY;
    logic [31:0] MD_RESULT;
    logic        MD_RESULT_SEL;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    ex_muldiv_unit dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .EX_Opcode    (EX_Opcode),
        .EX_Funct     (EX_Funct),
        .EX_RS_Data   (EX_RS_Data),
        .EX_RT_Data   (EX_RT_Data),
        .MD_STALL     (MD_STALL),
        .MD_BUSY      (MD_BUSY),
        .MD_RESULT    (MD_RESULT),
        .MD_RESULT_SEL(MD_RESULT_SEL),
        .HI           (HI),
        .LO           (LO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference arithmetic done in 64-bit integers; SV division truncates toward zero
    // and the remainder takes the dividend's sign, matching the required semantics.
    task automatic ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, p, q, r;
        if (f == F_MULT || f == F_DIV) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        if (f == F_MULT || f == F_MULTU) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endtask

    task automatic drive_nop();
        EX_Opcode  = 6'h00;
        EX_Funct   = 6'h00;
        EX_RS_Data = 32'd0;
        EX_RT_Data = 32'd0;
    endtask

    // Issues an op right after a rising edge, counts the stall run, checks HI/LO in the
    // DONE cycle, then steps past the DONE->IDLE edge with the op still held.
    task automatic run_op(input string name, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int stall_n, busy_n, guard;
        ref_model(f, a, b, eh, el);
        EX_Opcode  = 6'h00;
        EX_Funct   = f;
        EX_RS_Data = a;
        EX_RT_Data = b;
        stall_n = 0;
        busy_n  = 0;
        guard   = 0;
        @(negedge CLK);
        while (MD_STALL === 1'b1 && guard < 100) begin
            stall_n++;
            if (MD_BUSY === 1'b1) busy_n++;
            guard++;
            @(negedge CLK);
        end
        n_checks++;
        if (stall_n != 33) begin
            n_fail++;
            $display("FAIL %s stall_len: got %0d want 33", name, stall_n);
        end
        n_checks++;
        if (busy_n != 32) begin
            n_fail++;
            $display("FAIL %s busy_len: got %0d want 32", name, busy_n);
        end
        n_checks++;
        if (HI !== eh || LO !== el) begin
            n_fail++;
            $display("FAIL %s result: got HI=%h LO=%h want HI=%h LO=%h", name, HI, LO, eh, el);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if (MD_BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL %s restart_from_done: MD_BUSY got %b want 0", name, MD_BUSY);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        drive_nop();
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (HI !== 32'd0 || LO !== 32'd0 || MD_BUSY !== 1'b0 || MD_STALL !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got HI=%h LO=%h busy=%b stall=%b want 0 0 0 0",
                     HI, LO, MD_BUSY, MD_STALL);
        end
        RESET = 1'b0;
    endtask

    task automatic test_directed();
        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++;
        if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL multu_max_const: got HI=%h LO=%h want fffffffe 00000001", HI, LO);
        end
        run_op("mult_neg3x7", F_MULT, 32'hFFFF_FFFD, 32'd7);
        n_checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFEB) begin
            n_fail++;
            $display("FAIL mult_neg3x7_const: got HI=%h LO=%h want ffffffff ffffffeb", HI, LO);
        end
        run_op("div_neg7by2", F_DIV, 32'hFFFF_FFF9, 32'd2);
        n_checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_neg7by2_const: got HI=%h LO=%h want ffffffff fffffffd", HI, LO);
        end
        run_op("divu_7by2", F_DIVU, 32'd7, 32'd2);
        n_checks++;
        if (HI !== 32'd1 || LO !== 32'd3) begin
            n_fail++;
            $display("FAIL divu_7by2_const: got HI=%h LO=%h want 1 3", HI, LO);
        end
        run_op("divu_5by0", F_DIVU, 32'd5, 32'd0);
        n_checks++;
        if (HI !== 32'd5 || LO !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL divu_5by0_const: got HI=%h LO=%h want 5 ffffffff", HI, LO);
        end
        run_op("div_neg_by0", F_DIV, 32'h8765_4321, 32'd0);
        run_op("div_min_by_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        n_checks++;
        if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL div_min_by_m1_const: got HI=%h LO=%h want 0 80000000", HI, LO);
        end
        run_op("mult_min_sq", F_MULT, 32'h8000_0000, 32'h8000_0000);
        drive_nop();
    endtask

    task automatic test_random();
        logic [5:0] fn_tab [4];
        logic [5:0] f;
        logic [31:0] a, b;
        fn_tab[0] = F_MULT;
        fn_tab[1] = F_MULTU;
        fn_tab[2] = F_DIV;
        fn_tab[3] = F_DIVU;
        for (int i = 0; i < 24; i++) begin
            f = fn_tab[$urandom_range(0, 3)];
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = -$urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run_op("random", f, a, b);
        end
        drive_nop();
    endtask

    task automatic test_move_hilo();
        logic [31:0] v;
        @(posedge CLK);
        #1;
        EX_Opcode = 6'h00; EX_Funct = F_MTHI; EX_RS_Data = 32'h0000_1234; EX_RT_Data = $urandom;
        @(negedge CLK);
        n_checks++;
        if (MD_STALL !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_stall: got %b want 0", MD_STALL);
        end
        @(posedge CLK);
        #1;
        EX_Funct = F_MFHI; EX_RS_Data = $urandom;
        @(negedge CLK);
        n_checks++;
        if (MD_RESULT !== 32'h0000_1234 || MD_RESULT_SEL !== 1'b1 || MD_STALL !== 1'b0) begin
            n_fail++;
            $display("FAIL mfhi_read: got res=%h sel=%b stall=%b want 00001234 1 0",
                     MD_RESULT, MD_RESULT_SEL, MD_STALL);
        end
        v = $urandom;
        @(posedge CLK);
        #1;
        EX_Funct = F_MTLO; EX_RS_Data = v;
        @(posedge CLK);
        #1;
        EX_Funct = F_MFLO; EX_RS_Data = $urandom;
        @(negedge CLK);
        n_checks++;
        if (MD_RESULT !== v || MD_RESULT_SEL !== 1'b1 || MD_STALL !== 1'b0 || HI !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL mflo_read: got res=%h sel=%b stall=%b HI=%h want %h 1 0 00001234",
                     MD_RESULT, MD_RESULT_SEL, MD_STALL, HI, v);
        end
        EX_Opcode = 6'h23;
        #1;
        n_checks++;
        if (MD_RESULT !== 32'd0 || MD_RESULT_SEL !== 1'b0) begin
            n_fail++;
            $display("FAIL non_rtype_decode: got res=%h sel=%b want 0 0", MD_RESULT, MD_RESULT_SEL);
        end
        EX_Funct = F_MULTU;
        #1;
        n_checks++;
        if (MD_STALL !== 1'b0) begin
            n_fail++;
            $display("FAIL non_rtype_mul_stall: got %b want 0", MD_STALL);
        end
        @(posedge CLK);
        #1;
        drive_nop();
    endtask

    task automatic test_reset_mid_op();
        EX_Opcode = 6'h00; EX_Funct = F_MULTU; EX_RS_Data = 32'd2; EX_RT_Data = 32'd3;
        repeat (11) @(posedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        n_checks++;
        if (MD_STALL !== 1'b0 || MD_BUSY !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: got stall=%b busy=%b HI=%h LO=%h want 0 0 0 0",
                     MD_STALL, MD_BUSY, HI, LO);
        end
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        run_op("reissue_multu_2x3", F_MULTU, 32'd2, 32'd3);
        n_checks++;
        if (HI !== 32'd0 || LO !== 32'd6) begin
            n_fail++;
            $display("FAIL reissue_const: got HI=%h LO=%h want 0 6", HI, LO);
        end
        drive_nop();
    endtask

    task automatic test_back_to_back();
        run_op("b2b_first", F_DIVU, 32'd100, 32'd7);
        run_op("b2b_second", F_MULT, 32'hFFFF_FF00, 32'h0001_0001);
        run_op("b2b_third", F_DIV, 32'h7FFF_FFFF, 32'hFFFF_FFFE);
        drive_nop();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_move_hilo();
        test_random();
        test_reset_mid_op();
        test_back_to_back();
        repeat (2) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
